mole_round_ctrl: RTL and testbench

//  Game-round sequencer for the key-match game. Draws the target key (key_random),

---
 rtl/game_pkg.sv | 24 ++
 rtl/lfsr16.sv | 26 ++
 rtl/mole_round_ctrl.sv | 153 +++++++++++++++
 tb/tb_mole_round_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the key-match game: round states, voice codes and the
// feedback-window length that the change_voice decoder also keys off.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW     = 2'd1,
        FEEDBACK = 2'd2,
        OVER     = 2'd3
    } state_t;

    localparam logic [3:0] VOICE_HIT  = 4'hA;
    localparam logic [3:0] VOICE_MISS = 4'd6;
    localparam logic [3:0] VOICE_OFF  = 4'hF;

    localparam int unsigned FB_CYCLES_DEF = 32'd4_000_000;
    localparam int unsigned CNT_W         = 32'd26;

    // Fibonacci step, taps 16,14,13,11 (bits 15,13,12,10), shifting toward the MSB.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit LFSR used to draw the target key; never stops stepping,
// so the drawn key depends on when the player acts.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] r_q;

    // Advance one step every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else begin
            r_q <= lfsr16_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/mole_round_ctrl.sv
// Round sequencer for the key-match game: draws the target, times the answer window,
// drives the pressed/cnt feedback window and keeps score and lives.
module mole_round_ctrl
    import game_pkg::*;
#(
    parameter int unsigned ROUND_CYCLES = 32'd50_000_000,
    parameter int unsigned FB_CYCLES    = FB_CYCLES_DEF,
    parameter logic [1:0]  LIVES        = 2'd3,
    parameter int unsigned SCORE_W      = 32'd8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               key_valid,
    input  logic [3:0]         key,
    output logic [3:0]         key_random,
    output logic               pressed,
    output logic [25:0]        cnt,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               round_active,
    output logic               game_over
);

    localparam int unsigned TIMER_W = (ROUND_CYCLES > 32'd1) ? $clog2(ROUND_CYCLES) : 32'd1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ROUND_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0]   FB_LAST    = CNT_W'(FB_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    state_t               r_state;
    logic [TIMER_W-1:0]   r_timer;
    logic [CNT_W-1:0]     r_cnt;
    logic [3:0]           r_key_random;
    logic                 r_pressed;
    logic [SCORE_W-1:0]   r_score;
    logic [1:0]           r_lives;
    logic                 r_round_active;
    logic                 r_game_over;

    logic [15:0]          w_lfsr;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_hit;
    logic                 w_unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:4];
    assign w_cnt_inc     = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_hit         = (key == r_key_random);

    // Round FSM together with timer, feedback counter, score and lives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_timer        <= '0;
            r_cnt          <= '0;
            r_key_random   <= 4'd0;
            r_pressed      <= 1'b0;
            r_score        <= '0;
            r_lives        <= 2'd0;
            r_round_active <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pressed      <= 1'b0;
                    r_cnt          <= '0;
                    r_timer        <= '0;
                    r_round_active <= 1'b0;
                    r_game_over    <= 1'b0;
                    if (start) begin
                        r_lives        <= LIVES;
                        r_score        <= '0;
                        r_key_random   <= w_lfsr[3:0];
                        r_round_active <= 1'b1;
                        r_state        <= SHOW;
                    end
                end
                SHOW: begin
                    r_timer <= r_timer + TIMER_W'(1);
                    r_cnt   <= w_cnt_inc;
                    // A press on the timeout cycle takes priority over the timeout.
                    if (key_valid) begin
                        r_pressed      <= 1'b1;
                        r_cnt          <= '0;
                        r_round_active <= 1'b0;
                        r_state        <= FEEDBACK;
                        if (w_hit) begin
                            if (r_score != SCORE_MAX) begin
                                r_score <= r_score + SCORE_W'(1);
                            end
                        end else if (r_lives != 2'd0) begin
                            r_lives <= r_lives - 2'd1;
                        end
                    end else if (r_timer == TIMER_LAST) begin
                        r_cnt          <= '0;
                        r_round_active <= 1'b0;
                        r_state        <= FEEDBACK;
                        if (r_lives != 2'd0) begin
                            r_lives <= r_lives - 2'd1;
                        end
                    end
                end
                FEEDBACK: begin
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == FB_LAST) begin
                        r_pressed <= 1'b0;
                        if (r_lives == 2'd0) begin
                            r_game_over <= 1'b1;
                            r_state     <= OVER;
                        end else begin
                            r_key_random   <= w_lfsr[3:0];
                            r_timer        <= '0;
                            r_round_active <= 1'b1;
                            r_state        <= SHOW;
                        end
                    end
                end
                OVER: begin
                    r_pressed <= 1'b0;
                    r_cnt     <= w_cnt_inc;
                    if (start) begin
                        r_lives        <= LIVES;
                        r_score        <= '0;
                        r_key_random   <= w_lfsr[3:0];
                        r_timer        <= '0;
                        r_round_active <= 1'b1;
                        r_game_over    <= 1'b0;
                        r_state        <= SHOW;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign key_random   = r_key_random;
    assign pressed      = r_pressed;
    assign cnt          = r_cnt;
    assign score        = r_score;
    assign lives        = r_lives;
    assign round_active = r_round_active;
    assign game_over    = r_game_over;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomized scenario bench for mole_round_ctrl, checked against a game-rule model.
module tb_mole_round_ctrl;

    localparam int RC = 100;
    localparam int FB = 20;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key = 4'd0;
    logic [3:0]  key_random;
    logic        pressed;
    logic [25:0] cnt;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic        round_active;
    logic        game_over;

    int n_vec = 0;
    int n_err = 0;
    int m_score = 0;
    int m_lives = 0;
    logic [3:0]  m_key = 4'd0;
    logic [15:0] m_lfsr = SEED;

    always #5 clk = ~clk;

    mole_round_ctrl #(
        .ROUND_CYCLES (RC),
        .FB_CYCLES    (FB),
        .LIVES        (2'd3),
        .SCORE_W      (8),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key_valid    (key_valid),
        .key          (key),
        .key_random   (key_random),
        .pressed      (pressed),
        .cnt          (cnt),
        .score        (score),
        .lives        (lives),
        .round_active (round_active),
        .game_over    (game_over)
    );

    // Reference LFSR: x' = (x*2 mod 2^16) + parity of taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        int v;
        int fb;
        v  = int'(x);
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v * 2) % 65536) + fb);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, got time %0t, required < 5000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic apply_hit_or_miss(input logic [3:0] k);
        if (k == m_key) begin
            if (m_score < 255) m_score = m_score + 1;
        end else if (m_lives > 0) begin
            m_lives = m_lives - 1;
        end
    endtask

    task automatic start_game();
        logic [17:0] obs, exp;
        @(negedge clk);
        start = 1'b1;
        m_key = m_lfsr[3:0];
        @(negedge clk);
        start = 1'b0;
        m_lives = 3;
        m_score = 0;
        obs = {key_random, lives, score, round_active, game_over, pressed};
        exp = {m_key, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL start_load: got %h required %h", obs, exp);
        end
    endtask

    // From the first SHOW cycle, press key k when the round timer reads t.
    task automatic press_at(input int t, input logic [3:0] k);
        for (int j = 0; j < t; j++) begin
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        key_valid = 1'b1;
        key = k;
        apply_hit_or_miss(k);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic timeout_round();
        repeat (RC - 1) @(negedge clk);
        n_vec++;
        if ({round_active, pressed} !== 2'b10) begin
            n_err++;
            $display("FAIL show_last_cycle: got %b required 10", {round_active, pressed});
        end
        @(negedge clk);
        if (m_lives > 0) m_lives = m_lives - 1;
    endtask

    // Walk the whole feedback window, injecting ignored key/start pulses.
    task automatic run_feedback(input logic exp_pressed);
        logic [38:0] obs, exp;
        logic [17:0] o2, e2;
        logic [3:0]  nk;
        nk = 4'd0;
        for (int i = 0; i < FB; i++) begin
            obs = {pressed, round_active, game_over, lives, score, cnt};
            exp = {exp_pressed, 1'b0, 1'b0, 2'(m_lives), 8'(m_score), 26'(i)};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL feedback_cycle%0d: got %h required %h", i, obs, exp);
            end
            if (i == FB - 1) nk = m_lfsr[3:0];
            key_valid = (i < FB - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            start     = (i < FB - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            key       = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        key_valid = 1'b0;
        start = 1'b0;
        if (m_lives == 0) begin
            e2 = {1'b1, 1'b0, 1'b0, 2'd0, 8'(m_score), m_key};
        end else begin
            m_key = nk;
            e2 = {1'b0, 1'b1, 1'b0, 2'(m_lives), 8'(m_score), m_key};
        end
        o2 = {game_over, round_active, pressed, lives, score, key_random};
        n_vec++;
        if (o2 !== e2) begin
            n_err++;
            $display("FAIL feedback_exit: got %h required %h", o2, e2);
        end
    endtask

    task automatic test_reset();
        logic [43:0] obs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'($urandom_range(0, 1));
            key = 4'($urandom_range(0, 15));
            @(negedge clk);
            obs = {key_random, pressed, cnt, score, lives, round_active, game_over};
            n_vec++;
            if (obs !== 44'd0) begin
                n_err++;
                $display("FAIL idle_outputs%0d: got %h required 0", i, obs);
            end
        end
        key_valid = 1'b0;
    endtask

    task automatic test_hit();
        start_game();
        press_at(10, m_key);
        run_feedback(1'b1);
    endtask

    task automatic test_timeout_press();
        press_at(RC - 1, m_key);
        run_feedback(1'b1);
    endtask

    task automatic test_miss();
        press_at(5, m_key ^ 4'($urandom_range(1, 15)));
        run_feedback(1'b1);
    endtask

    task automatic test_timeout();
        timeout_round();
        run_feedback(1'b0);
    endtask

    task automatic test_game_over();
        logic [17:0] obs, exp;
        press_at(int'($urandom_range(0, 20)), m_key ^ 4'($urandom_range(1, 15)));
        run_feedback(1'b1);
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1;
            key = 4'($urandom_range(0, 15));
            @(negedge clk);
            obs = {game_over, round_active, pressed, lives, score, key_random};
            exp = {1'b1, 1'b0, 1'b0, 2'd0, 8'(m_score), m_key};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL over_hold%0d: got %h required %h", i, obs, exp);
            end
        end
        key_valid = 1'b0;
        start_game();
    endtask

    task automatic test_random_rounds();
        int t;
        logic [3:0] k;
        for (int r = 0; r < 10 && m_lives > 0; r++) begin
            t = int'($urandom_range(0, 110));
            k = ($urandom_range(0, 1) == 1) ? m_key : 4'($urandom_range(0, 15));
            if (t >= RC) begin
                timeout_round();
                run_feedback(1'b0);
            end else begin
                press_at(t, k);
                run_feedback(1'b1);
            end
        end
    endtask

    task automatic test_saturate_reset();
        logic [43:0] obs;
        logic [38:0] o1, e1;
        int stop;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_game();
        for (int h = 0; h < 255; h++) begin
            press_at(int'($urandom_range(0, 2)), m_key);
            run_feedback(1'b1);
        end
        press_at(0, m_key);
        stop = int'($urandom_range(3, 15));
        for (int i = 0; i < stop; i++) begin
            o1 = {pressed, round_active, game_over, lives, score, cnt};
            e1 = {1'b1, 1'b0, 1'b0, 2'd3, 8'd255, 26'(i)};
            n_vec++;
            if (o1 !== e1) begin
                n_err++;
                $display("FAIL saturated_hit%0d: got %h required %h", i, o1, e1);
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        obs = {key_random, pressed, cnt, score, lives, round_active, game_over};
        n_vec++;
        if (obs !== 44'd0) begin
            n_err++;
            $display("FAIL async_reset: got %h required 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs = {key_random, pressed, cnt, score, lives, round_active, game_over};
        n_vec++;
        if (obs !== 44'd0) begin
            n_err++;
            $display("FAIL after_reset_idle: got %h required 0", obs);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_hit();
        test_timeout_press();
        test_miss();
        test_timeout();
        test_game_over();
        test_random_rounds();
        test_saturate_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
